// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction-fetch path.
//   WORD_W        : CPU word width (instruction and address).
//   OP_BZ         : opcode of the branch-if-zero instruction. Decode and the
//                   bench use it; fetch never predecodes.
//   fetch_state_t : fetch controller states.
//   fetch_entry_t : one prefetch queue entry, {pc, instr}.
package fetch_pkg;

    localparam int         WORD_W = 16;
    localparam logic [3:0] OP_BZ  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// DEPTH-entry FIFO of {pc, instr} entries sitting between fetch and decode.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   push, push_pc,
//   push_instr            : write request and entry data
//   pop                   : remove the head entry
//   clear                 : drop all entries; wins over push and pop
//   full, empty           : occupancy flags
//   head_pc, head_instr   : registered head entry
// A push is accepted when the FIFO is full if a pop happens in the same cycle.
// Storage is reset to zero so the head outputs read zero out of reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_pc,
    input  logic [WORD_W-1:0] push_instr,
    input  logic              pop,
    input  logic              clear,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] head_pc,
    output logic [WORD_W-1:0] head_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign head_pc    = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Push together with pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller: owns the PC, reads the combinational
// instruction memory, and buffers {pc, instr} in a prefetch queue that feeds
// decode.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start                  : begin fetching (only looked at in IDLE)
//   pc_out / instr_in      : instruction memory address / same-cycle data
//   id_valid, id_ready     : decode handshake (see below)
//   id_instr, id_pc        : queue head entry
//   redirect, redirect_pc  : taken-branch pulse and its target
//   done                   : program exhausted and queue drained
//   state_dbg              : current FSM state (fetch_state_t encoding)
// Handshake: a word moves to decode on a rising edge where id_valid and
// id_ready are both high. id_valid is the queue's non-empty flag, gated off
// while redirect is high, because the head is then younger than the branch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PROG_LEN = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] pc_out,
    input  logic [WORD_W-1:0] instr_in,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam logic [WORD_W-1:0] PROG_END = WORD_W'(PROG_LEN);
    localparam logic [WORD_W-1:0] PC_INIT  = WORD_W'(RESET_PC);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;
    logic              q_full;
    logic              q_empty;
    logic              deq;
    logic              fetch_ok;
    logic              redirect_act;
    logic              enq;

    // Redirect means nothing before fetching has started.
    assign redirect_act = redirect && (state != IDLE);
    assign id_valid     = !q_empty && !redirect;
    assign deq          = id_valid && id_ready;
    // Fetch into a full queue only when the head leaves in the same cycle.
    assign fetch_ok     = (state == FETCH) && (pc < PROG_END) && (!q_full || deq);
    assign enq          = fetch_ok && !redirect_act;

    assign pc_out    = pc;
    assign done      = (state == DONE);
    assign state_dbg = state;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (enq),
        .push_pc    (pc),
        .push_instr (instr_in),
        .pop        (deq),
        .clear      (redirect_act),
        .full       (q_full),
        .empty      (q_empty),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= PC_INIT;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (pc >= PROG_END) state_next = DRAIN;
            DRAIN:   if (q_empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (fetch_ok) begin
            pc_next = pc + WORD_W'(1);
        end
        // A taken branch overrides fetch, drain and done alike.
        if (redirect_act) begin
            pc_next    = redirect_pc;
            state_next = (redirect_pc < PROG_END) ? FETCH : DRAIN;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with DEPTH=2, PROG_LEN=8, RESET_PC=0.
// An 8-word program ROM answers pc_out combinationally. A negedge monitor
// checks every decode transfer against the expected queue exp_q.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        done;
    logic [1:0]  state_dbg;

    logic [15:0] prog [8];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_sequencer #(
        .DEPTH(2),
        .PROG_LEN(8),
        .RESET_PC(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_out      (pc_out),
        .instr_in    (instr_in),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    assign instr_in = (pc_out < 16'd8) ? prog[pc_out[2:0]] : 16'h0000;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_exp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back({16'(i), prog[i]});
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL xfer_unexpected observed pc=%0h expected no transfer", id_pc);
            end
            if (exp_q.size() != 0) begin
                check("xfer_word", {id_pc, id_instr}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        prog[0] = 16'h1A80;
        prog[1] = 16'h6C88;
        prog[2] = 16'h2345;
        prog[3] = {OP_BZ, 12'h0F3};
        prog[4] = 16'h4410;
        prog[5] = 16'h5521;
        prog[6] = 16'h6632;
        prog[7] = 16'h7743;
        rst = 1'b1;
        start = 1'b0;
        id_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;

        // Reset values.
        tick();
        tick();
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", 32'(id_instr), 32'd0);
        check("rst_id_pc", 32'(id_pc), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        tick();
        tick();
        check("idle_hold", 32'(state_dbg), 32'(IDLE));
        check("idle_no_fetch", 32'(pc_out), 32'd0);

        // Full program streamed with id_ready high: one word per cycle.
        id_ready = 1'b1;
        push_exp(0, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_state_fetch", 32'(state_dbg), 32'(FETCH));
        check("t1_first_bubble", 32'(id_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_stream_valid", 32'(id_valid), 32'd1);
            check("t1_stream_pc", 32'(id_pc), 32'(i));
        end
        tick();
        check("t1_drain_valid", 32'(id_valid), 32'd0);
        check("t1_drain_done", 32'(done), 32'd0);
        check("t1_drain_state", 32'(state_dbg), 32'(DRAIN));
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_all_seen", 32'(exp_q.size()), 32'd0);

        // Backpressure: queue fills with DEPTH words, PC freezes.
        do_reset();
        id_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t2_pc_frozen", 32'(pc_out), 32'd2);
        check("t2_head_valid", 32'(id_valid), 32'd1);
        check("t2_head_pc", 32'(id_pc), 32'd0);
        check("t2_head_instr", 32'(id_instr), 32'h1A80);
        push_exp(0, 7);
        id_ready = 1'b1;
        wait_done("t2_done", 40);
        check("t2_all_seen", 32'(exp_q.size()), 32'd0);

        // Redirect out of DONE back into the program.
        push_exp(4, 7);
        redirect = 1'b1;
        redirect_pc = 16'd4;
        #1;
        check("t4_redir_valid", 32'(id_valid), 32'd0);
        tick();
        redirect = 1'b0;
        check("t4_done_drop", 32'(done), 32'd0);
        check("t4_pc", 32'(pc_out), 32'd4);
        wait_done("t4_done", 20);
        check("t4_all_seen", 32'(exp_q.size()), 32'd0);

        // Redirect to PROG_LEN: nothing fetched, done comes back.
        redirect = 1'b1;
        redirect_pc = 16'd8;
        tick();
        redirect = 1'b0;
        check("t5_done_drop", 32'(done), 32'd0);
        check("t5_state", 32'(state_dbg), 32'(DRAIN));
        check("t5_pc", 32'(pc_out), 32'd8);
        tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_no_valid", 32'(id_valid), 32'd0);

        // Redirect while the queue is full.
        do_reset();
        id_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t3_full_pc", 32'(pc_out), 32'd2);
        check("t3_full_valid", 32'(id_valid), 32'd1);
        push_exp(5, 7);
        redirect = 1'b1;
        redirect_pc = 16'd5;
        id_ready = 1'b1;
        #1;
        check("t3_redir_valid", 32'(id_valid), 32'd0);
        tick();
        redirect = 1'b0;
        check("t3_cleared", 32'(id_valid), 32'd0);
        check("t3_pc", 32'(pc_out), 32'd5);
        check("t3_state", 32'(state_dbg), 32'(FETCH));
        tick();
        check("t3_new_valid", 32'(id_valid), 32'd1);
        check("t3_new_pc", 32'(id_pc), 32'd5);
        wait_done("t3_done", 20);
        check("t3_all_seen", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two entries queued.
        do_reset();
        id_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_queued", 32'(id_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(id_valid), 32'd0);
        check("t6_async_pc", 32'(pc_out), 32'd0);
        check("t6_async_state", 32'(state_dbg), 32'(IDLE));
        check("t6_async_instr", 32'(id_instr), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t6_idle_state", 32'(state_dbg), 32'(IDLE));
        check("t6_idle_pc", 32'(pc_out), 32'd0);
        check("t6_idle_valid", 32'(id_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
